ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
- Single-clock FIFO controller that drives one ram_simple2port instance. The instance is built with RAM_PERFORMANCE="LOW_LATENCY", with clka = clkb = clk, rstb tied 0 and regceb tied 1.
- Generates write-side and read-side RAM addresses and enables, and absorbs the RAM's 1-cycle read latency.
- Presents the buffered data as a first-word-fall-through valid/ready stream.
- Sits between a frame producer (e.g. MAC RX) and the forwarding/queue logic in the TSN switch datapath.

Parameters:
- DATA_WIDTH, 32: payload width; must equal the RAM's RAM_WIDTH.
- DEPTH, 16: RAM entries; must equal RAM_DEPTH. Need not be a power of 2; minimum 2.
- AFULL_THRESH, 12: level at or above which afull asserts.
- ADDR_W, derived: clogb2(DEPTH-1), same function as the RAM.
- LVL_W, derived: clogb2(DEPTH+2).

Ports:
- clk  in  1  single clock for the block and the RAM.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear; same effect as rst.
- s_data  in  DATA_WIDTH  write data.
- s_valid  in  1  write request.
- s_ready  out  1  space available.
- m_data  out  DATA_WIDTH  head-of-queue data.
- m_valid  out  1  head data valid.
- m_ready  in  1  consumer accepts head.
- level  out  LVL_W  total entries held.
- afull  out  1  level >= AFULL_THRESH.
- ram_addra  out  ADDR_W  to RAM addra.
- ram_wea  out  1  to RAM wea.
- ram_dina  out  DATA_WIDTH  to RAM dina.
- ram_addrb  out  ADDR_W  to RAM addrb.
- ram_enb  out  1  to RAM enb.
- ram_doutb  in  DATA_WIDTH  from RAM doutb; valid the cycle after ram_enb.

Behaviour:
- State: wr_ptr, rd_ptr (ADDR_W); ram_cnt (0..DEPTH); inflight flag (registered ram_enb); 2-entry output buffer ob[0..1] with ob_cnt (0..2).
- Reset/flush values:
  - pointers, counts, inflight, ob_cnt all 0.
  - s_ready = 1, m_valid = 0, m_data = 0, level = 0, afull = 0.
  - RAM contents are not touched.
  - flush or rst asserted mid-operation discards every stored and in-flight word; a ram_doutb arriving the next cycle is ignored.
- Push: push = s_valid & s_ready, with s_ready = (ram_cnt < DEPTH), combinational from registers only.
  - ram_wea = push; ram_addra = wr_ptr; ram_dina = s_data.
  - wr_ptr advances on push and wraps from DEPTH-1 to 0.
- Pop: pop = m_valid & m_ready, with m_valid = (ob_cnt != 0) and m_data = ob[0]. On pop, ob shifts.
- Read issue (combinational):
  - ram_enb = (ram_cnt != 0) & ((ob_cnt + inflight - pop) <= 1); ram_addrb = rd_ptr.
  - rd_ptr advances on ram_enb and wraps from DEPTH-1 to 0.
  - ram_enb is never asserted in a cycle with rst or flush.
- Capture: when inflight = 1, ram_doutb is written into the first free ob slot after applying the same-cycle pop shift.
- ram_cnt next = ram_cnt + push - ram_enb; push and read issue in the same cycle are legal.
- Write-to-read ordering: a word is readable only from the cycle after its push, so no same-address write/read conflict is possible.
- level = ram_cnt + inflight + ob_cnt, combinational from registers; maximum DEPTH+2.
- Timing and throughput:
  - Latency: a word accepted in an idle FIFO in cycle 0 shows m_valid = 1 in cycle 3.
  - Sustained throughput is 1 word/cycle with m_ready held high.
  - m_data is stable while m_valid = 1 and m_ready = 0.
- Error handling:
  - Writes while s_ready = 0 are ignored, and the data is lost.
  - m_ready while m_valid = 0 has no effect.

Test Plan:
- Reset, then single push of 0xA5A5_0001 in cycle 0 with m_ready = 0 -> ram_enb = 1 in cycle 1; m_valid = 1 and m_data = 0xA5A5_0001 from cycle 3; level = 1 throughout.
- Push 18 words 0..17 back-to-back with m_ready = 0:
  - all 18 are accepted (16 in RAM, 2 in ob) and level = 18;
  - s_ready falls after the 18th;
  - a 19th push of 0xDEAD is ignored;
  - draining returns exactly 0..17 in order.
- Continuous push of 0..99 with m_ready = 1 -> output 0..99 in order, 1 word/cycle after a 3-cycle fill; level never exceeds 3.
- Wrap test with DEPTH = 16: push/pop 40 words, with m_ready toggling every 2 cycles -> no loss or duplication; ram_addra and ram_addrb each wrap 15 -> 0.
- With 10 words stored and a read in flight, assert flush for 1 cycle -> next cycle level = 0, m_valid = 0, s_ready = 1; the subsequent push of 0x55 emerges first.
- Push until level = 12 -> afull asserts in the cycle level reaches 12 and deasserts when level drops to 11.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around a simple dual-port RAM, presenting a first-word-fall-through valid/ready stream.
// Latency: a word pushed into an empty FIFO is visible on m_valid/m_data three cycles later; 1 word/cycle sustained.
// Backpressure: s_ready drops when the RAM is full; m_ready low holds the head word stable in the 2-entry output buffer.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 12,
    // Number of bits needed to hold DEPTH-1, matching the RAM's address width.
    localparam int ADDR_W      = $clog2(DEPTH),
    // Number of bits needed to hold DEPTH+2, the largest possible level.
    localparam int LVL_W       = $clog2(DEPTH + 3)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [LVL_W-1:0]      level,
    output logic                  afull,
    output logic [ADDR_W-1:0]     ram_addra,
    output logic                  ram_wea,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic [ADDR_W-1:0]     ram_addrb,
    output logic                  ram_enb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);

    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      ram_cnt_q, ram_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            ob_cnt_q, ob_cnt_d;
    logic [DATA_WIDTH-1:0] ob0_q, ob0_d;
    logic [DATA_WIDTH-1:0] ob1_q, ob1_d;

    logic                  clr;
    logic                  push;
    logic                  pop;
    logic [2:0]            ob_occ;
    logic [1:0]            cap_slot;

    assign clr = rst | flush;

    // Handshake, RAM port drive and read-issue decision, all derived from registered state.
    always_comb begin
        s_ready   = (ram_cnt_q < LVL_W'(DEPTH));
        m_valid   = (ob_cnt_q != 2'd0);
        m_data    = ob0_q;
        push      = s_valid & s_ready;
        pop       = m_valid & m_ready;
        ram_wea   = push;
        ram_addra = wr_ptr_q;
        ram_dina  = s_data;
        ram_addrb = rd_ptr_q;
        // Output-buffer slots that will be occupied once this cycle's pop and the in-flight word settle.
        ob_occ    = {1'b0, ob_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        // Only issue a read if its data is guaranteed a free slot when it returns next cycle.
        ram_enb   = (ram_cnt_q != '0) && (ob_occ <= 3'd1) && !clr;
        level     = ram_cnt_q + LVL_W'(inflight_q) + LVL_W'(ob_cnt_q);
        afull     = (level >= LVL_W'(AFULL_THRESH));
    end

    // Next-state for pointers, counters and the output buffer shift/capture.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ram_cnt_d  = ram_cnt_q;
        inflight_d = ram_enb;
        ob_cnt_d   = ob_cnt_q;
        ob0_d      = ob0_q;
        ob1_d      = ob1_q;
        cap_slot   = ob_cnt_q - {1'b0, pop};

        if (push) begin
            wr_ptr_d = (wr_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (ram_enb) begin
            rd_ptr_d = (rd_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        ram_cnt_d = ram_cnt_q + LVL_W'(push) - LVL_W'(ram_enb);

        // Pop shifts the buffer first; a returning RAM word then lands in the first free slot.
        if (pop) begin
            ob0_d = ob1_q;
        end
        if (inflight_q) begin
            if (cap_slot == 2'd0) begin
                ob0_d = ram_doutb;
            end else begin
                ob1_d = ram_doutb;
            end
        end
        ob_cnt_d = ob_cnt_q - {1'b0, pop} + {1'b0, inflight_q};
    end

    // State registers; reset and flush both discard all stored and in-flight words.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            ob_cnt_q   <= 2'd0;
            ob0_q      <= '0;
            ob1_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            ob_cnt_q   <= ob_cnt_d;
            ob0_q      <= ob0_d;
            ob1_q      <= ob1_d;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural low-latency simple dual-port RAM attached.
// Expected words are queued as pushes are accepted; a monitor pops and compares on each output handshake.
// Directed scenarios cover latency, full/overflow, streaming, pointer wrap, flush and almost-full.
module tb_ram_fifo_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int LW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [LW-1:0] level;
    logic          afull;
    logic [AW-1:0] ram_addra;
    logic          ram_wea;
    logic [DW-1:0] ram_dina;
    logic [AW-1:0] ram_addrb;
    logic          ram_enb;
    logic [DW-1:0] ram_doutb = '0;

    logic [DW-1:0] mem [DEPTH];

    int n_vec = 0;
    int n_err = 0;
    int pops  = 0;
    int max_lvl = 0;
    logic wrap_a = 1'b0, wrap_b = 1'b0;
    logic [AW-1:0] last_wa = '0, last_rb = '0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(12)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .level(level), .afull(afull),
        .ram_addra(ram_addra), .ram_wea(ram_wea), .ram_dina(ram_dina),
        .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_doutb(ram_doutb)
    );

    // Low-latency RAM: registered output, updated only when enb is high.
    always @(posedge clk) begin
        if (ram_wea) mem[ram_addra] <= ram_dina;
        if (ram_enb) ram_doutb <= mem[ram_addrb];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard producer: every accepted push queues its word as the next expected output.
    always @(negedge clk) begin
        if (!rst && !flush && s_valid && s_ready) exp_q.push_back(s_data);
    end

    // Scoreboard consumer plus level/wrap tracking.
    always @(negedge clk) begin
        if (!rst && !flush && m_valid && m_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop_unexpected: got 0x%08h expected no word", m_data);
            end else begin
                check("pop_data", m_data, exp_q.pop_front());
            end
        end
        if (int'(level) > max_lvl) max_lvl = int'(level);
        if (ram_wea) begin
            if (last_wa == AW'(DEPTH - 1) && ram_addra == '0) wrap_a = 1'b1;
            last_wa = ram_addra;
        end
        if (ram_enb) begin
            if (last_rb == AW'(DEPTH - 1) && ram_addrb == '0) wrap_b = 1'b1;
            last_rb = ram_addrb;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        tick();
        m_ready = 1'b1;
        t = 0;
        while (!(level == '0 && !m_valid) && t < 300) begin
            tick();
            t++;
        end
        if (t >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: level %0d expected 0", level);
        end
        m_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int sent;
        int cyc;
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data",  m_data, 32'd0);
        check("rst_level",   32'(level), 32'd0);
        check("rst_afull",   32'(afull), 32'd0);

        // Single word latency.
        tick(); s_valid = 1'b1; s_data = 32'hA5A5_0001;
        @(negedge clk);
        check("t1_c0_wea", 32'(ram_wea), 32'd1);
        check("t1_c0_addra", 32'(ram_addra), 32'd0);
        check("t1_c0_enb", 32'(ram_enb), 32'd0);
        tick(); s_valid = 1'b0;
        @(negedge clk);
        check("t1_c1_enb", 32'(ram_enb), 32'd1);
        check("t1_c1_addrb", 32'(ram_addrb), 32'd0);
        check("t1_c1_level", 32'(level), 32'd1);
        check("t1_c1_mvalid", 32'(m_valid), 32'd0);
        tick();
        @(negedge clk);
        check("t1_c2_level", 32'(level), 32'd1);
        check("t1_c2_mvalid", 32'(m_valid), 32'd0);
        tick();
        @(negedge clk);
        check("t1_c3_mvalid", 32'(m_valid), 32'd1);
        check("t1_c3_mdata", m_data, 32'hA5A5_0001);
        check("t1_c3_level", 32'(level), 32'd1);
        p0 = pops;
        drain();
        check("t1_pops", 32'(pops - p0), 32'd1);

        // Fill to capacity with the consumer stalled.
        for (int i = 0; i < 18; i++) begin
            tick(); s_valid = 1'b1; s_data = 32'(i);
            @(negedge clk);
            check("t2_s_ready", 32'(s_ready), 32'd1);
        end
        tick(); s_data = 32'hDEAD;
        @(negedge clk);
        check("t2_full_s_ready", 32'(s_ready), 32'd0);
        check("t2_full_level", 32'(level), 32'd18);
        check("t2_hold_mvalid", 32'(m_valid), 32'd1);
        check("t2_hold_mdata", m_data, 32'd0);
        tick(); s_valid = 1'b0;
        p0 = pops;
        drain();
        check("t2_pops", 32'(pops - p0), 32'd18);

        // Streaming at full rate.
        tick();
        p0 = pops; max_lvl = 0; m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'b1; s_data = 32'(i);
            tick();
        end
        s_valid = 1'b0;
        check("t3_pops_c100", 32'(pops - p0), 32'd97);
        repeat (3) tick();
        check("t3_pops_c103", 32'(pops - p0), 32'd100);
        check("t3_level_end", 32'(level), 32'd0);
        check("t3_max_level", 32'(max_lvl), 32'd3);
        m_ready = 1'b0;

        // Pointer wrap with a bursty consumer.
        tick();
        wrap_a = 1'b0; wrap_b = 1'b0; p0 = pops; sent = 0; cyc = 0;
        while (sent < 40 && cyc < 400) begin
            s_valid = 1'b1; s_data = 32'h1000 + 32'(sent);
            m_ready = (cyc % 4) >= 2;
            if (s_ready) sent++;
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        check("t4_sent", 32'(sent), 32'd40);
        drain();
        check("t4_pops", 32'(pops - p0), 32'd40);
        check("t4_wrap_a", 32'(wrap_a), 32'd1);
        check("t4_wrap_b", 32'(wrap_b), 32'd1);

        // Flush with a read in flight.
        tick();
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = 32'h2000 + 32'(i);
            tick();
        end
        s_valid = 1'b0;
        tick(); tick();
        p0 = pops; m_ready = 1'b1;
        @(negedge clk);
        check("t5_level10", 32'(level), 32'd10);
        check("t5_enb", 32'(ram_enb), 32'd1);
        tick(); m_ready = 1'b0; flush = 1'b1; exp_q.delete();
        @(negedge clk);
        check("t5_level9", 32'(level), 32'd9);
        check("t5_enb_flush", 32'(ram_enb), 32'd0);
        tick(); flush = 1'b0; s_valid = 1'b1; s_data = 32'h55;
        @(negedge clk);
        check("t5_post_level", 32'(level), 32'd0);
        check("t5_post_mvalid", 32'(m_valid), 32'd0);
        check("t5_post_sready", 32'(s_ready), 32'd1);
        check("t5_post_mdata", m_data, 32'd0);
        tick(); s_valid = 1'b0;
        drain();
        check("t5_pops", 32'(pops - p0), 32'd2);

        // Almost-full threshold.
        tick();
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1; s_data = 32'h3000 + 32'(i);
            @(negedge clk);
            check("t6_afull_low", 32'(afull), 32'd0);
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        check("t6_level12", 32'(level), 32'd12);
        check("t6_afull_on", 32'(afull), 32'd1);
        tick(); m_ready = 1'b0;
        @(negedge clk);
        check("t6_level11", 32'(level), 32'd11);
        check("t6_afull_off", 32'(afull), 32'd0);
        drain();
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
